song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Playlist controller that drives the song reader's play, song select and reset inputs.
- Converts one-cycle button pulses (play/pause, next, previous) and the reader's song_done into song selection and play gating.
- On every song change it holds the reader and note player in reset for a fixed number of cycles.
- Sits between the button debouncers and the song reader / note player.

Parameters:
SONG_WIDTH, 2, width of song select bus
NUM_SONGS, 4, number of songs in the ROM; 2 <= NUM_SONGS <= 2^SONG_WIDTH
RESET_CYCLES, 2, cycles reset_player is held per song change; 1..15

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
play_button  input  1  one-cycle pulse; toggle play/pause
next_button  input  1  one-cycle pulse; skip to next song
prev_button  input  1  one-cycle pulse; go to previous song
loop_mode  input  1  1 = wrap from last song to song 0 and keep playing
song_done  input  1  from song reader; high when current song finishes
play  output  1  play enable to song reader
song  output  SONG_WIDTH  song select to song reader
reset_player  output  1  reset to song reader and note player
playlist_done  output  1  one-cycle pulse when last song ends with loop_mode=0
busy  output  1  high while in SWITCH state

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high; all state is in registers.
- Reset values: state=PAUSED, song=0, play=0, reset_player=0, playlist_done=0, busy=0, resume=0, hold counter=0.
- States:
  - PAUSED: play=0.
  - PLAYING: play=1.
  - SWITCH: reset_player=1, busy=1, play=0.
- All outputs are registered. They reflect the state entered and take effect the cycle after the causing input.
- PAUSED:
  - next_button: song <= song+1 mod NUM_SONGS; resume<=0; enter SWITCH.
  - prev_button: song <= song-1 mod NUM_SONGS; resume<=0; enter SWITCH.
  - play_button: enter PLAYING.
  - song_done: ignored.
- PLAYING:
  - next_button / prev_button: same song update as PAUSED, but resume<=1; enter SWITCH.
  - song_done, song < NUM_SONGS-1: song<=song+1; resume<=1; enter SWITCH.
  - song_done, song == NUM_SONGS-1, loop_mode=1: song<=0; resume<=1; enter SWITCH.
  - song_done, song == NUM_SONGS-1, loop_mode=0: song<=0; resume<=0; playlist_done pulses for 1 cycle (the SWITCH-entry cycle); enter SWITCH.
  - play_button (no other event): enter PAUSED.
- SWITCH:
  - On entry the hold counter loads RESET_CYCLES-1.
  - Counter decrements each cycle; reset_player stays high for exactly RESET_CYCLES cycles.
  - When the counter is 0, the next state is PLAYING if resume=1, else PAUSED.
  - All button inputs and song_done are ignored (dropped, not queued) while in SWITCH.
- Input priority when several arrive in the same cycle: next_button > prev_button > song_done > play_button. Lower-priority events in that cycle are dropped.
- Modular arithmetic: wrap at NUM_SONGS, not 2^SONG_WIDTH.
  - NUM_SONGS=3: song 2 + next -> 0; song 0 + prev -> 2.
- song is stable for the whole of SWITCH and changes only on SWITCH entry.
- Reset asserted mid-SWITCH aborts the switch immediately; the following cycle shows reset values (reset_player=0).
- song_done held high across several cycles in PLAYING causes only one advance: the first cycle enters SWITCH, and later cycles are ignored there.

Test Plan:
- Reset, then play_button pulse -> play=1 one cycle later; song=0; reset_player=0 throughout.
- PLAYING song=1, next_button pulse -> song=2 next cycle; reset_player=1 for exactly 2 cycles, play=0 during them; then play=1.
- PLAYING song=3, loop_mode=0, song_done pulse -> song=0; playlist_done high 1 cycle; reset_player 2 cycles; then PAUSED with play=0.
- Same with loop_mode=1 -> song=0, no playlist_done, play=1 after reset_player drops; PAUSED song=0, prev_button -> song=3, still paused afterwards.
- Same-cycle next_button+play_button+song_done in PLAYING song=0 -> song=1 only, play resumes. Buttons pulsed during SWITCH -> no effect.
- RESET_CYCLES=5, NUM_SONGS=3: reset asserted on 3rd SWITCH cycle -> song=0, reset_player=0 next cycle. Song 2 + next -> 0.

Source files
------------

// File: rtl/song_sequencer.sv
// song_sequencer: playlist controller between the button debouncers and the
// song reader / note player. Turns play/next/prev pulses and song_done into
// a song select, a play enable and a timed reset pulse on every song change.
module song_sequencer #(
  parameter int SONG_WIDTH   = 2,
  parameter int NUM_SONGS    = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_button,
  input  logic                  next_button,
  input  logic                  prev_button,
  input  logic                  loop_mode,
  input  logic                  song_done,
  output logic                  play,
  output logic [SONG_WIDTH-1:0] song,
  output logic                  reset_player,
  output logic                  playlist_done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    SWITCH  = 2'd2
  } state_t;

  localparam logic [SONG_WIDTH-1:0] LAST_SONG = SONG_WIDTH'(NUM_SONGS - 1);
  localparam logic [3:0]            HOLD_LOAD = 4'(RESET_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [SONG_WIDTH-1:0]   song_q, song_d;
  logic                    resume_q, resume_d;
  logic [3:0]              hold_q, hold_d;
  logic                    play_q, play_d;
  logic                    reset_player_q, reset_player_d;
  logic                    playlist_done_q, playlist_done_d;
  logic                    busy_q, busy_d;

  // Wrap at NUM_SONGS rather than at the bus width.
  function automatic logic [SONG_WIDTH-1:0] song_inc(input logic [SONG_WIDTH-1:0] s);
    return (s == LAST_SONG) ? '0 : s + SONG_WIDTH'(1);
  endfunction

  function automatic logic [SONG_WIDTH-1:0] song_dec(input logic [SONG_WIDTH-1:0] s);
    return (s == '0) ? LAST_SONG : s - SONG_WIDTH'(1);
  endfunction

  // Next-state logic; priority next > prev > song_done > play, and every
  // input is dropped while a switch is in progress.
  always_comb begin
    state_d         = state_q;
    song_d          = song_q;
    resume_d        = resume_q;
    hold_d          = hold_q;
    playlist_done_d = 1'b0;

    case (state_q)
      PAUSED: begin
        if (next_button) begin
          song_d   = song_inc(song_q);
          resume_d = 1'b0;
          hold_d   = HOLD_LOAD;
          state_d  = SWITCH;
        end else if (prev_button) begin
          song_d   = song_dec(song_q);
          resume_d = 1'b0;
          hold_d   = HOLD_LOAD;
          state_d  = SWITCH;
        end else if (play_button) begin
          state_d = PLAYING;
        end
      end

      PLAYING: begin
        if (next_button) begin
          song_d   = song_inc(song_q);
          resume_d = 1'b1;
          hold_d   = HOLD_LOAD;
          state_d  = SWITCH;
        end else if (prev_button) begin
          song_d   = song_dec(song_q);
          resume_d = 1'b1;
          hold_d   = HOLD_LOAD;
          state_d  = SWITCH;
        end else if (song_done) begin
          hold_d  = HOLD_LOAD;
          state_d = SWITCH;
          if (song_q != LAST_SONG) begin
            song_d   = song_q + SONG_WIDTH'(1);
            resume_d = 1'b1;
          end else if (loop_mode) begin
            song_d   = '0;
            resume_d = 1'b1;
          end else begin
            song_d          = '0;
            resume_d        = 1'b0;
            playlist_done_d = 1'b1;
          end
        end else if (play_button) begin
          state_d = PAUSED;
        end
      end

      SWITCH: begin
        if (hold_q == '0) begin
          state_d = resume_q ? PLAYING : PAUSED;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end

      default: begin
        state_d = PAUSED;
      end
    endcase

    // Outputs are registered from the state being entered.
    play_d         = (state_d == PLAYING);
    reset_player_d = (state_d == SWITCH);
    busy_d         = (state_d == SWITCH);
  end

  // State and registered outputs; synchronous reset aborts any switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= PAUSED;
      song_q          <= '0;
      resume_q        <= 1'b0;
      hold_q          <= '0;
      play_q          <= 1'b0;
      reset_player_q  <= 1'b0;
      playlist_done_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      song_q          <= song_d;
      resume_q        <= resume_d;
      hold_q          <= hold_d;
      play_q          <= play_d;
      reset_player_q  <= reset_player_d;
      playlist_done_q <= playlist_done_d;
      busy_q          <= busy_d;
    end
  end

  assign play          = play_q;
  assign song          = song_q;
  assign reset_player  = reset_player_q;
  assign playlist_done = playlist_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: two instances (4 songs / 2 reset
// cycles and 3 songs / 5 reset cycles) share the input stimulus; each
// directed vector pushes the hand-computed outputs expected after the next
// clock edge, and a monitor pops and compares them for the selected instance.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       reset, play_button, next_button, prev_button, loop_mode, song_done;
  logic       a_play, a_reset_player, a_playlist_done, a_busy;
  logic [1:0] a_song;
  logic       b_play, b_reset_player, b_playlist_done, b_busy;
  logic [1:0] b_song;

  typedef struct {
    int id;
    bit sel;
    bit play;
    int song;
    bit rp;
    bit pd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;

  always #5 clk = ~clk;

  song_sequencer #(.SONG_WIDTH(2), .NUM_SONGS(4), .RESET_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .prev_button(prev_button),
    .loop_mode(loop_mode), .song_done(song_done),
    .play(a_play), .song(a_song), .reset_player(a_reset_player),
    .playlist_done(a_playlist_done), .busy(a_busy)
  );

  song_sequencer #(.SONG_WIDTH(2), .NUM_SONGS(3), .RESET_CYCLES(5)) dut_b (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .prev_button(prev_button),
    .loop_mode(loop_mode), .song_done(song_done),
    .play(b_play), .song(b_song), .reset_player(b_reset_player),
    .playlist_done(b_playlist_done), .busy(b_busy)
  );

  task automatic check(input string nm, input int id, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s vec%0d: got %0d want %0d", nm, id, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input bit sel, input bit rst, input bit pb, input bit nb,
                      input bit vb, input bit sd, input bit lm,
                      input bit e_play, input int e_song, input bit e_rp, input bit e_pd);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    play_button = pb;
    next_button = nb;
    prev_button = vb;
    song_done   = sd;
    loop_mode   = lm;
    vec_id++;
    e.id   = vec_id;
    e.sel  = sel;
    e.play = e_play;
    e.song = e_song;
    e.rp   = e_rp;
    e.pd   = e_pd;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!e.sel) begin
          check("a_play", e.id, int'(a_play), int'(e.play));
          check("a_song", e.id, int'(a_song), e.song);
          check("a_reset_player", e.id, int'(a_reset_player), int'(e.rp));
          check("a_busy", e.id, int'(a_busy), int'(e.rp));
          check("a_playlist_done", e.id, int'(a_playlist_done), int'(e.pd));
        end else begin
          check("b_play", e.id, int'(b_play), int'(e.play));
          check("b_song", e.id, int'(b_song), e.song);
          check("b_reset_player", e.id, int'(b_reset_player), int'(e.rp));
          check("b_busy", e.id, int'(b_busy), int'(e.rp));
          check("b_playlist_done", e.id, int'(b_playlist_done), int'(e.pd));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; play_button = 1'b0; next_button = 1'b0;
    prev_button = 1'b0; song_done = 1'b0; loop_mode = 1'b0;

    // Instance A: 4 songs, reset_player held 2 cycles.
    //   sel rst pb nb vb sd lm | play song rp pd
    step(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0);  // play
    step(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0);  // next while playing
    step(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0,   0, 2, 1, 0);  // song 1 -> 2
    step(0, 0, 0, 0, 0, 0, 0,   0, 2, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   1, 2, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0,   0, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   0, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1);  // last song ends, no loop
    step(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // paused
    step(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0,   0, 3, 1, 0);  // prev wraps 0 -> 3 while paused
    step(0, 0, 0, 0, 0, 0, 0,   0, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 0);  // still paused
    step(0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0);  // last song ends, loop on
    step(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);  // resumes playing
    step(0, 0, 1, 1, 0, 1, 0,   0, 1, 1, 0);  // next wins over done/play
    step(0, 0, 1, 0, 1, 1, 0,   0, 1, 1, 0);  // ignored during switch
    step(0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0);  // ignored on last switch cycle
    step(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0,   0, 2, 1, 0);  // song_done held high
    step(0, 0, 0, 0, 0, 1, 0,   0, 2, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0,   1, 2, 0, 0);  // only one advance
    step(0, 0, 0, 0, 0, 0, 0,   1, 2, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0,   0, 2, 0, 0);  // pause
    step(0, 0, 0, 0, 0, 1, 0,   0, 2, 0, 0);  // song_done ignored when paused
    step(0, 0, 0, 1, 1, 0, 0,   0, 3, 1, 0);  // next beats prev
    step(0, 0, 0, 0, 0, 0, 0,   0, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 0);  // back to paused

    // Instance B: 3 songs, reset_player held 5 cycles.
    step(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0);  // switch cycle 1
    step(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);  // 2
    step(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);  // 3
    step(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // reset aborts switch
    step(1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0,   0, 2, 1, 0);  // prev wraps 0 -> 2
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0,   1, 2, 0, 0);  // after exactly 5 cycles
    step(1, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0);  // next wraps 2 -> 0
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);

    @(negedge clk);
    play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0;
    song_done = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
